// File: rtl/m3_keycmdgen.sv
// m3_keycmdgen: operator key front-end for the three-phase motor controller.
// Synchronises and debounces seven raw push-buttons, derives start / force-stop /
// direction levels, and generates single-cycle frequency and power INC/DEC
// pulses with hold-then-repeat behaviour while a key is kept pressed.
module m3_keycmdgen #(
   parameter int CLK_PER_MS  = 1000,
   parameter int DEBOUNCE_MS = 20,
   parameter int HOLD_MS     = 500,
   parameter int REPEAT_MS   = 100
) (
   input  logic clkI,
   input  logic rstI,
   input  logic keyStartI,
   input  logic keyStopI,
   input  logic keyDirI,
   input  logic keyFreqUpI,
   input  logic keyFreqDownI,
   input  logic keyPowerUpI,
   input  logic keyPowerDownI,
   output logic m3startO,
   output logic m3forceStopO,
   output logic m3invRotateO,
   output logic m3freqINCo,
   output logic m3freqDECo,
   output logic m3powerINCo,
   output logic m3powerDECo
);

   localparam int MSW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [MSW-1:0] MS_LAST   = MSW'(CLK_PER_MS - 1);
   localparam logic [7:0]     DEB_LAST  = 8'(DEBOUNCE_MS - 1);
   localparam logic [9:0]     HOLD_LAST = 10'(HOLD_MS - 1);
   localparam logic [9:0]     REP_LAST  = 10'(REPEAT_MS - 1);

   // key bit positions inside the packed key vectors
   localparam int K_START = 0;
   localparam int K_STOP  = 1;
   localparam int K_DIR   = 2;
   localparam int K_FUP   = 3;
   localparam int K_FDN   = 4;
   localparam int K_PUP   = 5;
   localparam int K_PDN   = 6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } rpt_state_t;

   logic [6:0]       w_raw;
   logic [6:0]       r_sync1;
   logic [6:0]       r_sync2;
   logic [6:0]       r_deb;
   logic [6:0][7:0]  r_cnt;
   logic [1:0]       r_edge_d;       // {dir, start} debounced levels, one cycle late
   logic [MSW-1:0]   r_ms_cnt;
   logic             w_tick;
   logic             w_stop;
   logic             w_rise_start;
   logic             w_rise_dir;
   logic             r_start;
   logic             r_force_stop;
   logic             r_inv;

   // pair index 0 = frequency, 1 = power
   logic [1:0]       w_up;
   logic [1:0]       w_dn;
   logic [1:0]       w_act;
   logic [1:0]       w_act_rise;
   logic [1:0]       r_act_d;
   logic [1:0]       r_up_dir;
   logic [1:0]       r_inc;
   logic [1:0]       r_dec;
   rpt_state_t [1:0] r_state;
   logic [1:0][9:0]  r_tmr;

   assign w_raw = {keyPowerDownI, keyPowerUpI, keyFreqDownI, keyFreqUpI,
                   keyDirI, keyStopI, keyStartI};

   assign w_tick       = (r_ms_cnt == MS_LAST);
   assign w_stop       = r_deb[K_STOP];
   assign w_rise_start = r_deb[K_START] & ~r_edge_d[0];
   assign w_rise_dir   = r_deb[K_DIR]   & ~r_edge_d[1];

   assign w_up       = {r_deb[K_PUP], r_deb[K_FUP]};
   assign w_dn       = {r_deb[K_PDN], r_deb[K_FDN]};
   assign w_act      = w_up ^ w_dn;           // exactly one key of the pair held
   assign w_act_rise = w_act & ~r_act_d;

   assign m3startO     = r_start;
   assign m3forceStopO = r_force_stop;
   assign m3invRotateO = r_inv;
   assign m3freqINCo   = r_inc[0];
   assign m3freqDECo   = r_dec[0];
   assign m3powerINCo  = r_inc[1];
   assign m3powerDECo  = r_dec[1];

   // Two-flop synchroniser bringing the asynchronous keys into the clock domain
   always_ff @(posedge clkI) begin
      if (rstI) begin
         r_sync1 <= 7'b0;
         r_sync2 <= 7'b0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Free-running millisecond prescaler; w_tick marks its last count
   always_ff @(posedge clkI) begin
      if (rstI) begin
         r_ms_cnt <= MSW'(0);
      end else if (w_tick) begin
         r_ms_cnt <= MSW'(0);
      end else begin
         r_ms_cnt <= r_ms_cnt + MSW'(1);
      end
   end

   // Per-key debounce: a change is accepted only after DEBOUNCE_MS consecutive mismatching ticks
   always_ff @(posedge clkI) begin
      if (rstI) begin
         r_deb <= 7'b0;
         r_cnt <= '{default: 8'd0};
      end else begin
         for (int k = 0; k < 7; k++) begin
            if (r_sync2[k] == r_deb[k]) begin
               r_cnt[k] <= 8'd0;
            end else if (w_tick) begin
               if (r_cnt[k] == DEB_LAST) begin
                  r_deb[k] <= ~r_deb[k];
                  r_cnt[k] <= 8'd0;
               end else begin
                  r_cnt[k] <= r_cnt[k] + 8'd1;
               end
            end
         end
      end
   end

   // Start/stop/direction levels; stop dominates start, direction frozen while running
   always_ff @(posedge clkI) begin
      if (rstI) begin
         r_edge_d     <= 2'b00;
         r_start      <= 1'b0;
         r_force_stop <= 1'b0;
         r_inv        <= 1'b0;
      end else begin
         r_edge_d     <= {r_deb[K_DIR], r_deb[K_START]};
         r_force_stop <= w_stop;
         if (w_stop) begin
            r_start <= 1'b0;
         end else if (w_rise_start) begin
            r_start <= 1'b1;
         end
         if (w_rise_dir && !r_start) begin
            r_inv <= ~r_inv;
         end
      end
   end

   // Hold/repeat pulse generators for the frequency and power key pairs
   always_ff @(posedge clkI) begin
      if (rstI) begin
         r_act_d  <= 2'b00;
         r_up_dir <= 2'b00;
         r_inc    <= 2'b00;
         r_dec    <= 2'b00;
         r_state  <= {ST_IDLE, ST_IDLE};
         r_tmr    <= '{default: 10'd0};
      end else begin
         r_act_d <= w_act;
         r_inc   <= 2'b00;
         r_dec   <= 2'b00;
         for (int p = 0; p < 2; p++) begin
            if (w_stop) begin
               r_state[p] <= ST_IDLE;
               r_tmr[p]   <= 10'd0;
            end else begin
               case (r_state[p])
                  ST_IDLE: begin
                     if (w_act_rise[p]) begin
                        r_state[p]  <= ST_HOLD;
                        r_tmr[p]    <= 10'd0;
                        r_up_dir[p] <= w_up[p];
                        r_inc[p]    <= w_up[p];
                        r_dec[p]    <= ~w_up[p];
                     end
                  end
                  ST_HOLD: begin
                     if (!w_act[p]) begin
                        r_state[p] <= ST_IDLE;
                        r_tmr[p]   <= 10'd0;
                     end else if (w_tick) begin
                        if (r_tmr[p] == HOLD_LAST) begin
                           r_state[p] <= ST_REPEAT;
                           r_tmr[p]   <= 10'd0;
                           r_inc[p]   <= r_up_dir[p];
                           r_dec[p]   <= ~r_up_dir[p];
                        end else begin
                           r_tmr[p] <= r_tmr[p] + 10'd1;
                        end
                     end
                  end
                  ST_REPEAT: begin
                     if (!w_act[p]) begin
                        r_state[p] <= ST_IDLE;
                        r_tmr[p]   <= 10'd0;
                     end else if (w_tick) begin
                        if (r_tmr[p] == REP_LAST) begin
                           r_tmr[p] <= 10'd0;
                           r_inc[p] <= r_up_dir[p];
                           r_dec[p] <= ~r_up_dir[p];
                        end else begin
                           r_tmr[p] <= r_tmr[p] + 10'd1;
                        end
                     end
                  end
                  default: begin
                     r_state[p] <= ST_IDLE;
                     r_tmr[p]   <= 10'd0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: doc/m3_keycmdgen.md
# m3_keyCmdGen

Operator front-end for the three-phase motor controller. Takes seven raw, bouncy, asynchronous push-button inputs and produces the command set consumed by the power/speed calculation block:
- start level
- force-stop level
- rotate-direction level
- single-cycle frequency and power INC/DEC pulses, with auto-repeat while a key is held

Runs on the 1 MHz system clock.

## Interface
Parameters:
- CLK_PER_MS, 1000, clock cycles per millisecond tick (1 MHz clock)
- DEBOUNCE_MS, 20, stable time required to accept a key change
- HOLD_MS, 500, hold time before auto-repeat starts
- REPEAT_MS, 100, auto-repeat pulse interval

Ports:
- clkI  in  1  system clock, one clock domain
- rstI  in  1  synchronous, active-high reset
- keyStartI, keyStopI, keyDirI  in  1 each  raw keys, active-high, asynchronous
- keyFreqUpI, keyFreqDownI, keyPowerUpI, keyPowerDownI  in  1 each  raw keys, active-high, asynchronous
- m3startO  out  1  run request level
- m3forceStopO  out  1  emergency/stop level
- m3invRotateO  out  1  direction select level
- m3freqINCo, m3freqDECo, m3powerINCo, m3powerDECo  out  1 each  single-cycle command pulses

## Operation
Input synchronisation:
- Each raw key passes through a 2-flop synchroniser (syncK).

Millisecond tick:
- Counter 0..CLK_PER_MS-1.
- tick=1 for one cycle when the count equals CLK_PER_MS-1; the counter then wraps to 0.

Debounce, per key: debounced level debK, stability counter cntK (8 bits).
- Any cycle with syncK==debK clears cntK.
- On tick with syncK!=debK: if cntK==DEBOUNCE_MS-1, debK flips and cntK clears; otherwise cntK increments.
- A glitch shorter than one tick never changes debK.
- Rising edge riseK = debK & ~debK_d (one cycle).

Start/stop:
- m3forceStopO = debStop.
- m3startO is set on riseStart when debStop==0.
- m3startO is cleared on any cycle with debStop==1; stop has priority over a simultaneous start.

Direction:
- riseDir toggles m3invRotateO only when m3startO==0.
- While running, riseDir is ignored, with no deferred toggle.

Auto-repeat FSM, one instance per pair (freq, power). States IDLE, HOLD, REPEAT; timer tmr, 10 bits, counts ticks.
- Pair-active condition: exactly one of up/down debounced high. Both high, or neither, counts as inactive.
- IDLE -> HOLD on the rising edge of the pair-active condition. Emit one pulse on the active direction's output that cycle; tmr=0.
- HOLD: tmr increments on tick. When tmr==HOLD_MS-1 on a tick: emit a pulse, tmr=0, go to REPEAT.
- REPEAT: tmr increments on tick. When tmr==REPEAT_MS-1 on a tick: emit a pulse, tmr=0.
- HOLD/REPEAT -> IDLE, with no pulse, in the same cycle the pair becomes inactive. This covers release, and pressing the opposite key.
- Released opposite key: if the other key is still held after the opposite key releases, the pair is active again, so IDLE->HOLD with a new first pulse.
- Pulse direction is latched at IDLE->HOLD.
- INC and DEC outputs of a pair are never high in the same cycle.

Force-stop gating:
- While debStop==1, both FSMs are held in IDLE and emit no pulses.

## Timing
- Reset: every output 0. All debK, cntK, FSMs (IDLE), timers and the tick counter are cleared.
- Reset mid-hold: no pulse in the reset cycle or the cycle after.
- Raw edge to debK flip: 2 sync cycles plus between (DEBOUNCE_MS-1)·CLK_PER_MS+1 and DEBOUNCE_MS·CLK_PER_MS cycles.
- debK rise to first pulse, m3startO set, or m3invRotateO toggle: 1 cycle (registered outputs).
- m3forceStopO follows debStop with 1 cycle of latency.
- Pulse width: exactly 1 clock.
- First to second pulse: HOLD_MS ticks. Subsequent pulse spacing: REPEAT_MS ticks = REPEAT_MS·CLK_PER_MS cycles exactly.
- Timer width: 10 bits. HOLD_MS and REPEAT_MS must be in 1..1023. DEBOUNCE_MS must be in 1..255.

## Test plan
Bench parameters: CLK_PER_MS=10, DEBOUNCE_MS=3, HOLD_MS=5, REPEAT_MS=2.
- Glitch and debounce: 8-cycle pulses on keyFreqUpI repeated 5 times, then a steady high.
  - No pulse during the glitches.
  - Exactly one m3freqINCo 23..33 cycles after the steady edge.
- Auto-repeat: hold keyPowerDownI for 200 cycles.
  - First pulse, then a pulse 50 cycles later, then pulses every 20 cycles until release.
  - No pulse after the release is debounced.
- Both keys: hold keyFreqUpI, then press keyFreqDownI.
  - INC stops once both are debounced.
  - Releasing Down restarts with a new first INC pulse.
  - DEC is never asserted.
- Start/stop priority:
  - Press start: m3startO=1.
  - Press start and stop together: m3startO=0, m3forceStopO=1.
  - INC/DEC keys held during stop give zero pulses.
- Direction:
  - riseDir with m3startO=0 toggles m3invRotateO 0->1.
  - riseDir with m3startO=1 leaves it unchanged.
- Reset: assert rstI for 1 cycle during REPEAT.
  - All outputs 0 next cycle.
  - With the key still held, a new first pulse follows after the full debounce time.
